// File: rtl/video_sync_decoder.sv
// Camera sync front end: registers the raw LVAL/FVAL/strobe interface, tracks column/row,
// applies the active-window crop and keeps frame / short-line statistics.
// Optional feature macro: VIDEO_SYNC_TEST_PATTERN_EN (adds tp_enable, pixel = col+row).
module video_sync_decoder #(
  parameter int PIX_W    = 12,
  parameter int COL_W    = 11,
  parameter int ROW_W    = 11,
  parameter int H_START  = 0,
  parameter int H_ACTIVE = 1024,
  parameter int V_START  = 0,
  parameter int V_ACTIVE = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] cam_pixel,
  input  logic             cam_strobe,
  input  logic             cam_lval,
  input  logic             cam_fval,
`ifdef VIDEO_SYNC_TEST_PATTERN_EN
  input  logic             tp_enable,
`endif
  output logic [PIX_W-1:0] vid_pixel,
  output logic             vid_pixsync,
  output logic             vid_hblank,
  output logic             vid_vblank,
  output logic             vid_visible,
  output logic [COL_W-1:0] vid_col,
  output logic [ROW_W-1:0] vid_row,
  output logic [15:0]      stat_frames,
  output logic [7:0]       stat_short,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_FBLANK, ST_LINE} state_t;

  localparam logic [COL_W-1:0] COL_MAX = '1;
  localparam logic [ROW_W-1:0] ROW_MAX = '1;
  localparam logic [COL_W:0]   H_LO = (COL_W+1)'(H_START);
  localparam logic [COL_W:0]   H_HI = (COL_W+1)'(H_START + H_ACTIVE);
  localparam logic [ROW_W:0]   V_LO = (ROW_W+1)'(V_START);
  localparam logic [ROW_W:0]   V_HI = (ROW_W+1)'(V_START + V_ACTIVE);
  localparam int               SUM_W = ((COL_W > ROW_W) ? COL_W : ROW_W) + 1;

  state_t             state, next_state;
  logic [PIX_W-1:0]   pix_q;
  logic               strobe_q, lval_q, fval_q;
  logic [COL_W-1:0]   col, col_cur, col_inc;
  logic [ROW_W-1:0]   row, row_inc;
  logic               line_start, line_end, frame_start, emit;
  logic               h_ok, v_ok, short_hit;
  logic [PIX_W-1:0]   pix_src;
  logic [SUM_W-1:0]   tp_sum;

  // fval_q resets high so SYNC only leaves after a real fval=0 has been sampled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_q    <= '0;
      strobe_q <= 1'b0;
      lval_q   <= 1'b0;
      fval_q   <= 1'b1;
    end else begin
      pix_q    <= cam_pixel;
      strobe_q <= cam_strobe;
      lval_q   <= cam_lval;
      fval_q   <= cam_fval;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_SYNC;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_SYNC:   if (!fval_q) next_state = ST_IDLE;
      ST_IDLE:   if (fval_q) next_state = ST_FBLANK;
      ST_FBLANK: if (!fval_q) next_state = ST_IDLE;
                 else if (lval_q) next_state = ST_LINE;
      ST_LINE:   if (!fval_q) next_state = ST_IDLE;
                 else if (!lval_q) next_state = ST_FBLANK;
      default:   next_state = ST_SYNC;
    endcase
  end

  // The FBLANK->LINE cycle already belongs to the new line, so a strobe there is col 0.
  always_comb begin
    frame_start = (state == ST_IDLE) && fval_q;
    line_start  = (state == ST_FBLANK) && fval_q && lval_q;
    line_end    = (state == ST_LINE) && (!fval_q || !lval_q);
    emit        = strobe_q && (line_start || ((state == ST_LINE) && fval_q && lval_q));
    col_cur     = line_start ? '0 : col;
    col_inc     = (col_cur == COL_MAX) ? col_cur : col_cur + 1'b1;
    row_inc     = (row == ROW_MAX) ? row : row + 1'b1;
    h_ok        = ({1'b0, col_cur} >= H_LO) && ({1'b0, col_cur} < H_HI) && (col_cur != COL_MAX);
    v_ok        = ({1'b0, row} >= V_LO) && ({1'b0, row} < V_HI);
    short_hit   = line_end && ({1'b0, col} < H_HI) && v_ok;
    tp_sum      = SUM_W'(col_cur) + SUM_W'(row);
  end

`ifdef VIDEO_SYNC_TEST_PATTERN_EN
  assign pix_src = tp_enable ? PIX_W'(tp_sum) : pix_q;
`else
  assign pix_src = pix_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      vid_pixel   <= '0;
      vid_pixsync <= 1'b0;
      vid_visible <= 1'b0;
      vid_hblank  <= 1'b1;
      vid_vblank  <= 1'b1;
      vid_col     <= '0;
      vid_row     <= '0;
      col         <= '0;
      row         <= '0;
      stat_frames <= '0;
      stat_short  <= '0;
    end else begin
      vid_pixsync <= emit;
      vid_visible <= emit && h_ok && v_ok;
      vid_hblank  <= (next_state != ST_LINE);
      vid_vblank  <= (next_state == ST_SYNC) || (next_state == ST_IDLE);
      if (emit) begin
        vid_pixel <= pix_src;
        vid_col   <= col_cur;
        vid_row   <= row;
        col       <= col_inc;
      end else if (line_start) begin
        col <= '0;
      end
      if (frame_start) begin
        stat_frames <= stat_frames + 16'd1;
        stat_short  <= '0;
        row         <= '0;
      end
      if (line_end) row <= row_inc;
      if (short_hit && stat_short != 8'hFF) stat_short <= stat_short + 8'd1;
    end
  end

  assign dbg_state = state;

  logic unused_tp;
  assign unused_tp = ^tp_sum;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder using a scaled-down window (16..47 cols, rows 2..5)
// so saturation, cropping and short-line cases fit in a few thousand cycles.
module tb_video_sync_decoder;
  localparam int PIX_W = 12;
  localparam int COL_W = 6;
  localparam int ROW_W = 4;
  localparam int H_START = 16;
  localparam int H_ACTIVE = 32;
  localparam int V_START = 2;
  localparam int V_ACTIVE = 4;
  localparam int CMAX = (1 << COL_W) - 1;
  localparam int RMAX = (1 << ROW_W) - 1;
  localparam int EW = 32 + PIX_W + COL_W + ROW_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PIX_W-1:0] cam_pixel = '0;
  logic             cam_strobe = 1'b0;
  logic             cam_lval = 1'b0;
  logic             cam_fval = 1'b0;
  logic             tp_enable = 1'b0;
  logic [PIX_W-1:0] vid_pixel;
  logic             vid_pixsync, vid_hblank, vid_vblank, vid_visible;
  logic [COL_W-1:0] vid_col;
  logic [ROW_W-1:0] vid_row;
  logic [15:0]      stat_frames;
  logic [7:0]       stat_short;
  logic [1:0]       dbg_state;

  video_sync_decoder #(
    .PIX_W(PIX_W), .COL_W(COL_W), .ROW_W(ROW_W), .H_START(H_START),
    .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .cam_pixel(cam_pixel), .cam_strobe(cam_strobe),
    .cam_lval(cam_lval), .cam_fval(cam_fval),
`ifdef VIDEO_SYNC_TEST_PATTERN_EN
    .tp_enable(tp_enable),
`endif
    .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync), .vid_hblank(vid_hblank),
    .vid_vblank(vid_vblank), .vid_visible(vid_visible), .vid_col(vid_col),
    .vid_row(vid_row), .stat_frames(stat_frames), .stat_short(stat_short),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_col = 0;
  int m_row = 0;
  int m_frames = 0;
  int m_short = 0;
  logic [EW-1:0] exp_q[$];

  // scoreboard: every emitted pixel is matched against the queue head
  task automatic tick();
    logic [EW-1:0] e, a;
    logic [31:0]   stamp;
    @(negedge clk);
    if (vid_pixsync === 1'b1) begin
      checks++;
      a = {32'(cyc), vid_pixel, vid_col, vid_row, vid_visible};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixsync cyc=%0d col=%0d row=%0d", cyc, vid_col, vid_row);
      end else begin
        e = exp_q.pop_front();
        if (a !== e || vid_hblank !== 1'b0 || vid_vblank !== 1'b0) begin
          errors++;
          $display("FAIL pixel_out got cyc/pix/col/row/vis=%0d/%h/%0d/%0d/%b hb=%b vb=%b expected %0d/%h/%0d/%0d/%b",
                   a[EW-1 -: 32], vid_pixel, vid_col, vid_row, vid_visible, vid_hblank, vid_vblank,
                   e[EW-1 -: 32], e[PIX_W+COL_W+ROW_W:COL_W+ROW_W+1], e[COL_W+ROW_W:ROW_W+1],
                   e[ROW_W:1], e[0]);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      stamp = e[EW-1 -: 32];
      if (stamp >= 32'(cyc)) break;
      checks++;
      errors++;
      $display("FAIL missing_pixsync expected at cyc %0d, now %0d", stamp, cyc);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic push_pixel(input logic [PIX_W-1:0] pix);
    int c;
    logic vis;
    logic [PIX_W-1:0] p;
    c = (m_col > CMAX) ? CMAX : m_col;
    vis = (c >= H_START) && (c < H_START + H_ACTIVE) && (c != CMAX) &&
          (m_row >= V_START) && (m_row < V_START + V_ACTIVE);
    p = tp_enable ? PIX_W'(c + m_row) : pix;
    exp_q.push_back({32'(cyc + 2), p, COL_W'(c), ROW_W'(m_row), vis});
    m_col++;
  endtask

  task automatic start_frame(input bit lead);
    cam_fval = 1'b1;
    m_frames++;
    m_short = 0;
    m_row = 0;
    if (lead) repeat (3) tick();
  endtask

  task automatic end_frame();
    cam_fval = 1'b0;
    cam_lval = 1'b0;
    cam_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drive_line(input int n_px, input bit rise_strobe, input bit fall_strobe,
                            input bit drop_fval);
    m_col = 0;
    cam_lval = 1'b1;
    cam_strobe = rise_strobe;
    cam_pixel = PIX_W'($urandom_range(0, 4095));
    if (rise_strobe) push_pixel(cam_pixel);
    tick();
    cam_strobe = 1'b0;
    tick();
    for (int i = 0; i < n_px; i++) begin
      cam_pixel = PIX_W'($urandom_range(0, 4095));
      cam_strobe = 1'b1;
      push_pixel(cam_pixel);
      tick();
      cam_strobe = 1'b0;
      tick();
    end
    if (drop_fval) cam_fval = 1'b0;
    else cam_lval = 1'b0;
    cam_strobe = fall_strobe;
    cam_pixel = PIX_W'($urandom_range(0, 4095));
    tick();
    cam_strobe = 1'b0;
    repeat (3) tick();
    if (m_col < H_START + H_ACTIVE && m_row >= V_START && m_row < V_START + V_ACTIVE &&
        m_short < 255) m_short++;
    if (m_row < RMAX) m_row++;
  endtask

  task automatic check_stats(input string name);
    checks++;
    if (stat_frames !== 16'(m_frames) || stat_short !== 8'(m_short)) begin
      errors++;
      $display("FAIL %s stats got frames=%0d short=%0d expected frames=%0d short=%0d",
               name, stat_frames, stat_short, m_frames, m_short);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b0;
    cam_fval = 1'b1;
    cam_lval = 1'b1;
    cam_strobe = 1'b1;
    cam_pixel = 12'hABC;
    repeat (3) tick();
    checks++;
    if (vid_pixsync !== 1'b0 || vid_visible !== 1'b0 || vid_hblank !== 1'b1 ||
        vid_vblank !== 1'b1 || vid_pixel !== '0 || vid_col !== '0 || vid_row !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ps=%b vis=%b hb=%b vb=%b pix=%h col=%0d row=%0d expected 0 0 1 1 0 0 0",
               vid_pixsync, vid_visible, vid_hblank, vid_vblank, vid_pixel, vid_col, vid_row);
    end
    check_stats("reset");
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d expected 0", dbg_state);
    end
    cam_strobe = 1'b0;
    tick();
    rst = 1'b1;
    // frame already running when reset releases: nothing may be emitted
    for (int l = 0; l < 3; l++) begin
      cam_lval = 1'b1;
      for (int i = 0; i < 20; i++) begin
        cam_strobe = 1'b1;
        tick();
        cam_strobe = 1'b0;
        tick();
        checks++;
        if (vid_vblank !== 1'b1 || vid_pixsync !== 1'b0) begin
          errors++;
          $display("FAIL sync_hold got vb=%b ps=%b expected vb=1 ps=0", vid_vblank, vid_pixsync);
        end
      end
      cam_lval = 1'b0;
      repeat (3) tick();
    end
    end_frame();
    check_stats("after_sync");
  endtask

  task automatic test_full_frame();
    start_frame(1'b1);
    for (int l = 0; l < 18; l++) drive_line((l == 3) ? 70 : 50, 1'b0, 1'b0, 1'b0);
    check_stats("full_frame");
    end_frame();
    checks++;
    if (vid_hblank !== 1'b1 || vid_vblank !== 1'b1) begin
      errors++;
      $display("FAIL frame_end_blank got hb=%b vb=%b expected 1 1", vid_hblank, vid_vblank);
    end
  endtask

  task automatic test_short_line();
    start_frame(1'b1);
    drive_line(30, 1'b0, 1'b0, 1'b0);
    check_stats("short_outside_vwin");
    drive_line(50, 1'b0, 1'b0, 1'b0);
    drive_line(30, 1'b0, 1'b0, 1'b0);
    check_stats("short_row2");
    drive_line(48, 1'b0, 1'b0, 1'b0);
    check_stats("exact_width_not_short");
    drive_line(47, 1'b0, 1'b0, 1'b0);
    check_stats("one_short");
    end_frame();
    start_frame(1'b1);
    check_stats("short_cleared");
    end_frame();
  endtask

  task automatic test_fval_drop();
    start_frame(1'b1);
    drive_line(50, 1'b0, 1'b0, 1'b0);
    drive_line(50, 1'b0, 1'b0, 1'b0);
    drive_line(20, 1'b0, 1'b0, 1'b1);
    checks++;
    if (vid_hblank !== 1'b1 || vid_vblank !== 1'b1) begin
      errors++;
      $display("FAIL fval_drop_blank got hb=%b vb=%b expected 1 1", vid_hblank, vid_vblank);
    end
    check_stats("fval_drop_short");
    end_frame();
  endtask

  task automatic test_coincident_edges();
    // fval and lval rise together; then strobes on lval rise and on lval fall
    start_frame(1'b0);
    drive_line(10, 1'b0, 1'b0, 1'b0);
    drive_line(10, 1'b1, 1'b1, 1'b0);
    drive_line(50, 1'b1, 1'b1, 1'b0);
    check_stats("coincident");
    end_frame();
  endtask

`ifdef VIDEO_SYNC_TEST_PATTERN_EN
  task automatic test_pattern();
    start_frame(1'b1);
    tp_enable = 1'b1;
    for (int l = 0; l < 6; l++) drive_line(20, 1'b0, 1'b0, 1'b0);
    tp_enable = 1'b0;
    end_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_short_line();
    test_fval_drop();
    test_coincident_edges();
`ifdef VIDEO_SYNC_TEST_PATTERN_EN
    test_pattern();
`endif
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
